// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// func3 access encodings and the timeout counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store lane replication, byte enables and
// alignment check on the request side; byte/half extraction and extension on load data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_func3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_legal,
    output logic [3:0]  lane_be,
    output logic [31:0] lane_wdata,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign ld_shift = ld_word >> {ld_off, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
        req_legal  = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        case (req_func3)
            F3_B, F3_BU: begin
                req_legal  = 1'b1;
                lane_be    = 4'b0001 << req_off;
                lane_wdata = {4{req_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                req_legal  = ~req_off[0];
                lane_be    = 4'b0011 << req_off;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                req_legal  = (req_off == 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = req_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_shift;
        case (ld_func3)
            F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
            F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns core load/store strobes into a single
// valid/ready bus transaction, stalls the core meanwhile and aborts on timeout.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_func3,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT);

    lsu_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           off_q;
    logic [2:0]           func3_q;
    logic                 we_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [3:0]           be_q;
    logic [DATA_W-1:0]    rdata_q;

    logic              req_any, req_legal, accept, busy, timed_out;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata, ld_data;

    lsu_lane_align u_lane (
        .req_func3  (req_func3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .req_legal  (req_legal),
        .lane_be    (lane_be),
        .lane_wdata (lane_wdata),
        .ld_func3   (func3_q),
        .ld_off     (off_q),
        .ld_word    (bus_rdata),
        .ld_data    (ld_data)
    );

    assign req_any   = req_rd | req_wr;
    assign accept    = (state_q == IDLE) && req_any && req_legal;
    assign busy      = (state_q == REQ) || (state_q == RESP);
    assign timed_out = busy && (cnt_q == TMO);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (timed_out)      state_d = DONE;
                else if (bus_ready) begin
                    if (we_q) state_d = DONE;
                    else      state_d = RESP;
                end
            end
            RESP: if (timed_out || bus_rvalid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            func3_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                off_q   <= req_addr[1:0];
                func3_q <= req_func3;
                we_q    <= req_wr;
                wdata_q <= lane_wdata;
                be_q    <= lane_be;
                cnt_q   <= '0;
            end else if (busy && !timed_out) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Only loads own rdata: an aborted load clears it, stores leave it alone.
            if (timed_out && !we_q) begin
                rdata_q <= '0;
            end else if ((state_q == RESP) && bus_rvalid) begin
                rdata_q <= ld_data;
            end
        end
    end

    // Request-driven outputs are gated by reset so they read 0 while rst is low.
    assign stall     = rst && (accept || busy);
    assign misalign  = rst && (state_q == IDLE) && req_any && !req_legal;
    assign done      = (state_q == DONE);
    assign bus_err   = timed_out;
    assign bus_valid = (state_q == REQ) && !timed_out;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed vector table, reset corner
// sequence, then randomized accesses checked against a behavioural model.
module tb_lsu_bus_ctrl;

    localparam int TMO = 8;

    logic        clk, rst;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rword;
        int          dr, dv;
        logic        exp_mis, exp_err;
        int          exp_stall;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rdata;
    } vec_t;

    lsu_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/ctrl"}, 32'({stall, done, misalign, bus_err, bus_valid, bus_we, bus_be}), 32'h0);
        check({tag, "/bus_addr"}, bus_addr, 32'h0);
        check({tag, "/bus_wdata"}, bus_wdata, 32'h0);
        check({tag, "/rdata"}, rdata, 32'h0);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rword, input int dr, input int dv,
                                input logic mis, input logic err, input int stl,
                                input logic [3:0] be, input logic [31:0] ewd,
                                input logic [31:0] erd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rword = rword;
        v.dr = dr; v.dv = dv; v.exp_mis = mis; v.exp_err = err; v.exp_stall = stl;
        v.exp_be = be; v.exp_wdata = ewd; v.exp_rdata = erd;
        return v;
    endfunction

    // Reference model: access outcome from size/offset arithmetic and the cycle budget.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t        e;
        int          size, o, needed, bits;
        logic [31:0] val;
        e = v;
        o = int'(v.addr % 32'd4);
        if (v.f3 == 3'd0 || v.f3 == 3'd4)      size = 1;
        else if (v.f3 == 3'd1 || v.f3 == 3'd5) size = 2;
        else                                   size = 4;
        e.exp_mis   = (v.f3 == 3'd3) || (v.f3 >= 3'd6) || ((o % size) != 0);
        e.exp_be    = 4'(((1 << size) - 1) << o);
        if (size == 1)      e.exp_wdata = (v.wdata & 32'hFF) * 32'h01010101;
        else if (size == 2) e.exp_wdata = (v.wdata & 32'hFFFF) * 32'h00010001;
        else                e.exp_wdata = v.wdata;
        e.exp_err   = 1'b0;
        e.exp_stall = 0;
        e.exp_rdata = prev;
        if (!e.exp_mis) begin
            needed = v.dr + 1 + (v.wr ? 0 : v.dv + 1);
            if (needed > TMO) begin
                e.exp_err   = 1'b1;
                e.exp_stall = TMO + 2;
                if (!v.wr) e.exp_rdata = 32'h0;
            end else begin
                e.exp_stall = needed + 1;
                if (!v.wr) begin
                    bits = 8 * size;
                    val  = v.rword >> (8 * o);
                    if (size < 4) begin
                        val = val % (32'd1 << bits);
                        if (v.f3 < 3'd4 && val >= (32'd1 << (bits - 1))) val = val - (32'd1 << bits);
                    end
                    e.exp_rdata = val;
                end
            end
        end
        return e;
    endfunction

    // Core holds the request until done/misalign; the bus responder follows dr/dv.
    task automatic apply(input vec_t v, input string tag);
        int          cyc = 0, stall_n = 0, done_n = 0, err_n = 0, mis_n = 0;
        int          valid_n = 0, bad = 0, done_at = -1, vcount = 0, rcount = 0, exp_valid;
        logic        accepted = 1'b0, rv_sent = 1'b0, fin = 1'b0;
        logic [31:0] rd_at_done = 32'h0;
        while (!fin && cyc < 40) begin
            @(negedge clk);
            req_rd = v.rd; req_wr = v.wr; req_addr = v.addr;
            req_wdata = v.wdata; req_func3 = v.f3;
            bus_ready  = bus_valid && (vcount == v.dr);
            bus_rvalid = !v.wr && accepted && !rv_sent && (rcount == v.dv);
            bus_rdata  = bus_rvalid ? v.rword : $urandom;
            #1;
            if (stall) stall_n++;
            if (misalign) begin mis_n++; fin = 1'b1; end
            if (bus_err) err_n++;
            if (done) begin done_n++; done_at = cyc; rd_at_done = rdata; fin = 1'b1; end
            if (bus_valid) begin
                valid_n++;
                if (bus_addr !== (v.addr & 32'hFFFF_FFFC) || bus_we !== v.wr ||
                    bus_be !== v.exp_be || (v.wr && bus_wdata !== v.exp_wdata)) bad++;
            end
            if (accepted) rcount++;
            if (bus_rvalid) rv_sent = 1'b1;
            if (bus_valid && bus_ready) accepted = 1'b1;
            if (bus_valid) vcount++;
            cyc++;
        end
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        exp_valid = v.exp_mis ? 0 : ((v.dr + 1 < TMO) ? v.dr + 1 : TMO);
        check({tag, "/finished"}, 32'(fin), 32'd1);
        check({tag, "/misalign_cycles"}, mis_n, v.exp_mis ? 1 : 0);
        check({tag, "/stall_cycles"}, stall_n, v.exp_stall);
        check({tag, "/done_pulses"}, done_n, v.exp_mis ? 0 : 1);
        check({tag, "/bus_err_pulses"}, err_n, 32'(v.exp_err));
        check({tag, "/valid_cycles"}, valid_n, exp_valid);
        check({tag, "/bus_fields"}, bad, 0);
        if (!v.exp_mis) begin
            check({tag, "/done_cycle"}, done_at, v.exp_stall);
            check({tag, "/rdata_at_done"}, rd_at_done, v.exp_rdata);
        end
        check({tag, "/rdata_after"}, rdata, v.exp_rdata);
        check({tag, "/quiet_after"}, 32'({stall, done, misalign, bus_valid}), 32'h0);
        model_rdata = v.exp_rdata;
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        2,  0, 0, 0, 4,  4'hF, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(1, 0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0,  0, 0, 0, 3,  4'h8, 32'h0,        32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0,  0, 0, 0, 3,  4'h8, 32'h0,        32'h00000080);
        tbl[3]  = mk(0, 1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        0,  0, 0, 0, 2,  4'hC, 32'hABCDABCD, 32'h00000080);
        tbl[4]  = mk(1, 0, 3'd2, 32'h102, 32'h0,        32'h0,        0,  0, 1, 0, 0,  4'h0, 32'h0,        32'h00000080);
        tbl[5]  = mk(1, 0, 3'd3, 32'h000, 32'h0,        32'h0,        0,  0, 1, 0, 0,  4'h0, 32'h0,        32'h00000080);
        tbl[6]  = mk(0, 1, 3'd6, 32'h000, 32'h11111111, 32'h0,        0,  0, 1, 0, 0,  4'h0, 32'h0,        32'h00000080);
        tbl[7]  = mk(0, 1, 3'd0, 32'h101, 32'h12345678, 32'h0,        0,  0, 0, 0, 2,  4'h2, 32'h78787878, 32'h00000080);
        tbl[8]  = mk(1, 0, 3'd1, 32'h106, 32'h0,        32'h80017FFF, 1,  1, 0, 0, 5,  4'hC, 32'h0,        32'hFFFF8001);
        tbl[9]  = mk(1, 0, 3'd5, 32'h106, 32'h0,        32'h80017FFF, 1,  1, 0, 0, 5,  4'hC, 32'h0,        32'h00008001);
        tbl[10] = mk(1, 0, 3'd1, 32'h105, 32'h0,        32'h0,        0,  0, 1, 0, 0,  4'h0, 32'h0,        32'h00008001);
        tbl[11] = mk(1, 0, 3'd2, 32'h104, 32'h0,        32'h55555555, 20, 0, 0, 1, 10, 4'hF, 32'h0,        32'h0);
        tbl[12] = mk(1, 0, 3'd2, 32'h108, 32'h0,        32'hA5A55A5A, 3,  3, 0, 0, 9,  4'hF, 32'h0,        32'hA5A55A5A);
        tbl[13] = mk(1, 0, 3'd2, 32'h10C, 32'h0,        32'h77777777, 3,  4, 0, 1, 10, 4'hF, 32'h0,        32'h0);
        tbl[14] = mk(0, 1, 3'd2, 32'h110, 32'hCAFEBABE, 32'h0,        7,  0, 0, 0, 9,  4'hF, 32'hCAFEBABE, 32'h0);
        tbl[15] = mk(0, 1, 3'd2, 32'h110, 32'hCAFEBABE, 32'h0,        8,  0, 0, 1, 10, 4'hF, 32'hCAFEBABE, 32'h0);
        tbl[16] = mk(1, 1, 3'd2, 32'h120, 32'h01020304, 32'h0,        0,  0, 0, 0, 2,  4'hF, 32'h01020304, 32'h0);
        tbl[17] = mk(1, 0, 3'd0, 32'h121, 32'h0,        32'h00007F00, 0,  0, 0, 0, 3,  4'h2, 32'h0,        32'h0000007F);

        // Reset with live-looking inputs: everything must read 0.
        rst = 1'b0;
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h100; req_wdata = 32'hFFFFFFFF;
        req_func3 = 3'd2; bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk); @(negedge clk); #1;
        check_zero("reset");
        @(negedge clk);
        req_rd = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        rst = 1'b1;
        model_rdata = 32'h0;

        for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load waits in RESP, then a stale response after release.
        @(negedge clk);
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h300; req_func3 = 3'd2;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        @(negedge clk); bus_ready = 1'b1; #1;
        @(negedge clk); bus_ready = 1'b0; #1;
        check("rst_mid/in_resp", 32'({stall, bus_valid}), 32'h2);
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk); req_rd = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        check("stale/ctrl", 32'({stall, done, bus_err, bus_valid}), 32'h0);
        @(negedge clk); bus_rvalid = 1'b0; #1;
        check("stale/rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        apply(mk(1, 0, 3'd2, 32'h200, 32'h0, 32'h12345678, 0, 0, 0, 0, 3, 4'hF, 32'h0, 32'h12345678), "rst_then_lw");

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v = mk(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            v.rd = 1'($urandom_range(0, 1));
            v.wr = 1'($urandom_range(0, 1));
            if (!v.rd && !v.wr) v.rd = 1'b1;
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 1) == 1) v.addr = v.addr & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.rword = $urandom;
            v.dr    = $urandom_range(0, 4);
            v.dv    = $urandom_range(0, 3);
            v = model(v, model_rdata);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
